// File: rtl/mult8_sequencer.sv
// Sequencer for the signed shift-add multiplier: owns X/A/B and the multiplicand latch, drives an external adder.
// Done rises 17 edges after IDLE samples Run; Run/ClearA_LoadB are ignored while Busy, and DONE holds until Run drops.
module mult8_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH:0]   add_a,
  output logic [WIDTH:0]   add_b,
  output logic             add_cin,
  input  logic [WIDTH:0]   add_sum,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sm_q, sm_d;
  logic              x_q, x_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sub;
  logic [WIDTH:0]    sm_ext;

  // The final iteration weighs the multiplier's sign bit negatively, so it subtracts.
  assign sub     = (state_q == ADD) && (count_q == LAST);
  assign sm_ext  = {sm_q[WIDTH-1], sm_q};
  assign add_a   = {a_q[WIDTH-1], a_q};
  assign add_b   = sub ? ~sm_ext : sm_ext;
  assign add_cin = sub;

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    x_d     = x_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end else if (Run) begin
          state_d = CLR;
        end
      end
      CLR: begin
        a_d     = '0;
        x_d     = 1'b0;
        sm_d    = S;
        count_d = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) begin
          a_d = add_sum[WIDTH-1:0];
          x_d = add_sum[WIDTH];
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        if (count_q == LAST) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    busy_d = (state_d == CLR) || (state_d == ADD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= '0;
      x_q     <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      x_q     <= x_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
